// File: rtl/branch_predictor.sv
`timescale 1ns/1ps
// branch_predictor: next-PC predictor (static not-taken / bimodal / gshare) with BHT, BTB and perf counters.
// Latency: IF lookup and EX resolution are combinational; table, GHR and counter writes land on the next clk edge.
// Backpressure: none toward IF; ex_stall holds off the update and mispredict until EX advances.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   if_pc                 fetch PC            -> pred_next_pc, pred_taken, pred_ghr
//   ex_valid, ex_stall    EX handshake (update fires when ex_valid && !ex_stall)
//   ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target
//                         resolved instruction in EX
//   ex_pred_next_pc, ex_ghr
//                         prediction and GHR snapshot carried down with the instruction
//   mispredict, redirect_pc
//                         squash request and correct next PC
//   branch_count, mispredict_count
//                         free-running performance counters (wrap mod 2^32)
module branch_predictor #(
  parameter int MODE         = 1,   // 0 static not-taken, 1 bimodal, 2 gshare
  parameter int BHT_IDX_BITS = 6,   // BHT depth = 2^BHT_IDX_BITS, also the GHR width
  parameter int BTB_IDX_BITS = 5,   // BTB depth = 2^BTB_IDX_BITS, direct mapped
  parameter int CTR_BITS     = 2    // saturating counter width, 1..4
) (
  input  logic                    clk,
  input  logic                    rst,
  // IF lookup
  input  logic [31:0]             if_pc,
  output logic [31:0]             pred_next_pc,
  output logic                    pred_taken,
  output logic [BHT_IDX_BITS-1:0] pred_ghr,
  // EX resolution
  input  logic                    ex_valid,
  input  logic                    ex_stall,
  input  logic [31:0]             ex_pc,
  input  logic                    ex_is_branch,
  input  logic                    ex_is_jump,
  input  logic                    ex_taken,
  input  logic [31:0]             ex_target,
  input  logic [31:0]             ex_pred_next_pc,
  input  logic [BHT_IDX_BITS-1:0] ex_ghr,
  output logic                    mispredict,
  output logic [31:0]             redirect_pc,
  // performance counters
  output logic [31:0]             branch_count,
  output logic [31:0]             mispredict_count
);

  localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_BITS    = 32 - BTB_IDX_BITS - 2;

  // Weakly not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

  localparam bit USE_TABLES = (MODE != 0);
  localparam bit USE_GHR    = (MODE == 2);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CTR_BITS-1:0]     r_bht     [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0]  r_btb_vld;
  logic [BTB_ENTRIES-1:0]  r_btb_jmp;
  logic [TAG_BITS-1:0]     r_btb_tag [BTB_ENTRIES];
  logic [31:0]             r_btb_tgt [BTB_ENTRIES];
  logic [BHT_IDX_BITS-1:0] r_ghr;
  logic [31:0]             r_branch_cnt;
  logic [31:0]             r_mispred_cnt;

  // --------------------------------------------------------------------------
  // IF-side lookup
  // --------------------------------------------------------------------------
  logic [31:0]             w_if_pc_plus4;
  logic [BHT_IDX_BITS-1:0] w_if_bht_idx;
  logic [BTB_IDX_BITS-1:0] w_if_btb_idx;
  logic [TAG_BITS-1:0]     w_if_tag;
  logic [CTR_BITS-1:0]     w_if_ctr;
  logic                    w_if_hit;

  assign w_if_pc_plus4 = if_pc + 32'd4;
  // Bimodal uses the PC bits directly; gshare folds the live GHR in.
  assign w_if_bht_idx  = if_pc[BHT_IDX_BITS+1:2] ^ (USE_GHR ? r_ghr : '0);
  assign w_if_btb_idx  = if_pc[BTB_IDX_BITS+1:2];
  assign w_if_tag      = if_pc[31:BTB_IDX_BITS+2];
  assign w_if_ctr      = r_bht[w_if_bht_idx];
  assign w_if_hit      = r_btb_vld[w_if_btb_idx] && (r_btb_tag[w_if_btb_idx] == w_if_tag);

  // Reads state only, so an update in the same cycle is not visible here.
  always_comb begin
    pred_taken   = 1'b0;
    pred_next_pc = w_if_pc_plus4;
    if (USE_TABLES && w_if_hit && (r_btb_jmp[w_if_btb_idx] || w_if_ctr[CTR_BITS-1])) begin
      pred_taken   = 1'b1;
      pred_next_pc = r_btb_tgt[w_if_btb_idx];
    end
  end

  assign pred_ghr = r_ghr;

  // --------------------------------------------------------------------------
  // EX-side resolution
  // --------------------------------------------------------------------------
  logic [31:0]             w_ex_pc_plus4;
  logic                    w_ex_ctrl;
  logic [31:0]             w_ex_actual;
  logic                    w_ex_fire;
  logic [BHT_IDX_BITS-1:0] w_ex_bht_idx;
  logic [BTB_IDX_BITS-1:0] w_ex_btb_idx;
  logic [TAG_BITS-1:0]     w_ex_tag;
  logic [CTR_BITS-1:0]     w_ex_ctr;
  logic [CTR_BITS-1:0]     w_ex_ctr_nxt;
  logic [BHT_IDX_BITS:0]   w_ghr_shift;

  assign w_ex_pc_plus4 = ex_pc + 32'd4;
  assign w_ex_ctrl     = ex_is_branch | ex_is_jump;
  assign w_ex_actual   = (w_ex_ctrl && ex_taken) ? ex_target : w_ex_pc_plus4;
  // A stalled EX instruction will be seen again; act only once it moves on.
  assign w_ex_fire     = ex_valid && !ex_stall;

  assign mispredict    = w_ex_fire && (w_ex_actual != ex_pred_next_pc);
  assign redirect_pc   = w_ex_actual;

  // Train the counter the instruction actually consulted, hence the carried ex_ghr.
  assign w_ex_bht_idx  = ex_pc[BHT_IDX_BITS+1:2] ^ (USE_GHR ? ex_ghr : '0);
  assign w_ex_btb_idx  = ex_pc[BTB_IDX_BITS+1:2];
  assign w_ex_tag      = ex_pc[31:BTB_IDX_BITS+2];
  assign w_ex_ctr      = r_bht[w_ex_bht_idx];

  always_comb begin
    w_ex_ctr_nxt = w_ex_ctr;
    if (ex_taken) begin
      if (w_ex_ctr != CTR_MAX) w_ex_ctr_nxt = w_ex_ctr + CTR_ONE;
    end else begin
      if (w_ex_ctr != '0) w_ex_ctr_nxt = w_ex_ctr - CTR_ONE;
    end
  end

  // Shift in the outcome; the extra top bit falls off when truncated.
  assign w_ghr_shift = {r_ghr, ex_taken};

  // --------------------------------------------------------------------------
  // Update enables
  // --------------------------------------------------------------------------
  logic w_bht_we;
  logic w_ghr_we;
  logic w_btb_alloc;
  logic w_btb_inval;

  assign w_bht_we    = USE_TABLES && w_ex_fire && ex_is_branch;
  assign w_ghr_we    = USE_GHR && w_ex_fire && ex_is_branch;
  // Taken branches and all jumps allocate; not-taken branches never do.
  assign w_btb_alloc = USE_TABLES && w_ex_fire &&
                       ((ex_is_branch && ex_taken) || (ex_is_jump && !ex_is_branch));
  // A non-control instruction that was predicted to redirect hit a stale or
  // aliased BTB entry; drop it so it does not keep costing a squash.
  assign w_btb_inval = w_ex_fire && !w_ex_ctrl && (ex_pred_next_pc != w_ex_pc_plus4);

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_INIT;
    end else if (w_bht_we) begin
      r_bht[w_ex_bht_idx] <= w_ex_ctr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btb_vld <= '0;
    end else if (w_btb_alloc) begin
      r_btb_vld[w_ex_btb_idx] <= 1'b1;
    end else if (w_btb_inval) begin
      r_btb_vld[w_ex_btb_idx] <= 1'b0;
    end
  end

  // Entry payload needs no reset: it is ignored until its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_btb_alloc) begin
      r_btb_tag[w_ex_btb_idx] <= w_ex_tag;
      r_btb_tgt[w_ex_btb_idx] <= ex_target;
      r_btb_jmp[w_ex_btb_idx] <= !ex_is_branch;
    end
  end

  // Non-speculative history: advanced at resolution, never repaired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_ghr_we) begin
      r_ghr <= w_ghr_shift[BHT_IDX_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_ex_fire && ex_is_branch) r_branch_cnt  <= r_branch_cnt + 32'd1;
      if (mispredict)                r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign branch_count     = r_branch_cnt;
  assign mispredict_count = r_mispred_cnt;

endmodule
